multih_traceback: RTL and testbench

- Survivor-path traceback unit for the multi-h trellis demodulator.
- Stores per-symbol branch decisions from the 4-way add-compare-select array (2-bit winner per state) in a circular survivor memory.
- On each new decision vector, traces back TB_LEN steps from the externally supplied best state and emits one decoded 4-ary symbol.
- Read-side counterpart of the ACS decision writer.

---
 rtl/multih_traceback.sv | 126 ++++++++++++
 tb/tb_multih_traceback.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/multih_traceback.sv
// ---------------------------------------------------------------------------
// multih_traceback
//   Survivor-path traceback for the multi-h trellis demodulator. Each accepted
//   decision vector (2-bit winner per trellis state) is written into a
//   circular survivor memory. Once TB_LEN vectors are present, every new
//   vector starts a traceback of TB_LEN steps from best_state. The trace
//   emits the 4-ary symbol that entered the path TB_LEN symbols earlier.
//
// Handshake: dec_valid is a one-cycle strobe and there is no back-pressure.
//   A strobe is accepted whenever busy=0, which includes the EMIT cycle.
//   A strobe that arrives while busy=1 is dropped and sets the sticky
//   overflow flag. sym_valid is a one-cycle pulse, and sym holds its value
//   until the next pulse.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   dec_valid   decision strobe (dec_vec/best_state valid)
//   dec_vec     decision for state s at bits [2s+1:2s]
//   best_state  state with the best path metric for this symbol
//   clear_ovf   clears overflow (a simultaneous drop wins)
//   busy        traceback in progress
//   sym_valid   decoded symbol strobe
//   sym         decoded symbol
//   overflow    sticky: a decision vector was dropped
//   state_dbg   current FSM state (IDLE=0, TRACE=1, EMIT=2)
// ---------------------------------------------------------------------------
module multih_traceback #(
  parameter int STATE_BITS = 6,
  parameter int TB_LEN     = 32,
  parameter int DEPTH      = 64
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            dec_valid,
  input  logic [2*(2**STATE_BITS)-1:0]    dec_vec,
  input  logic [STATE_BITS-1:0]           best_state,
  input  logic                            clear_ovf,
  output logic                            busy,
  output logic                            sym_valid,
  output logic [1:0]                      sym,
  output logic                            overflow,
  output logic [1:0]                      state_dbg
);

  localparam int NSTATES = 2**STATE_BITS;
  localparam int PW      = $clog2(DEPTH);
  localparam int FW      = $clog2(TB_LEN + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, TRACE = 2'd1, EMIT = 2'd2} state_t;

  state_t                   state_q, state_d;
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [FW-1:0]            fill, fill_next;
  logic [FW-1:0]            step_cnt;
  logic [STATE_BITS-1:0]    cur, cur_next;
  logic [1:0]               dec_bits;
  logic                     accept, fill_full;

  logic [2*NSTATES-1:0]     mem [DEPTH];
  logic [2*NSTATES-1:0]     rdata;

  assign accept    = dec_valid && (state_q != TRACE);
  assign fill_next = (fill == FW'(TB_LEN)) ? fill : fill + 1'b1;
  assign fill_full = (fill_next == FW'(TB_LEN));

  // One traceback step: the stored decision is the symbol that fell out of
  // the state window, so it becomes the MSBs of the predecessor state.
  assign dec_bits = rdata[{cur, 1'b0} +: 2];
  assign cur_next = {dec_bits, cur[STATE_BITS-1:2]};

  assign busy      = (state_q == TRACE);
  assign sym_valid = (state_q == EMIT);
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && fill_full) state_d = TRACE;
      // step_cnt==0 is the read-latency cycle; steps apply at 1..TB_LEN.
      TRACE:   if (step_cnt == FW'(TB_LEN)) state_d = EMIT;
      EMIT:    state_d = (accept && fill_full) ? TRACE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      step_cnt <= '0;
      cur      <= '0;
      sym      <= 2'b00;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_ptr   <= wr_ptr + 1'b1;
        rd_ptr   <= wr_ptr;
        cur      <= best_state;
        fill     <= fill_next;
        step_cnt <= '0;
      end else if (state_q == TRACE) begin
        // The read address runs one step ahead of the data being consumed.
        rd_ptr   <= rd_ptr - 1'b1;
        step_cnt <= step_cnt + 1'b1;
        if (step_cnt != '0) begin
          cur <= cur_next;
          if (step_cnt == FW'(TB_LEN)) sym <= cur_next[1:0];
        end
      end
      if (dec_valid && state_q == TRACE) overflow <= 1'b1;
      else if (clear_ovf)                overflow <= 1'b0;
    end
  end

  // Survivor memory. It is not reset; the fill count keeps stale rows
  // out of any traceback.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= dec_vec;
    rdata <= mem[rd_ptr];
  end

endmodule

// File: tb/tb_multih_traceback.sv
// ---------------------------------------------------------------------------
// tb_multih_traceback
//   Directed bench for multih_traceback. It covers the following cases:
//   - reset state;
//   - the fill threshold;
//   - a known trellis path across memory wrap;
//   - overflow set, clear, and set-wins behaviour;
//   - asynchronous reset, both mid-run and mid-trace.
//   Expected symbols are queued when a vector is issued. A monitor pops one
//   entry on each sym_valid pulse.
// ---------------------------------------------------------------------------
module tb_multih_traceback;

  localparam int SB  = 6;
  localparam int NS  = 64;
  localparam int TB  = 32;
  localparam int WIN = 36;

  logic              clk;
  logic              reset_n;
  logic              dec_valid;
  logic [2*NS-1:0]   dec_vec;
  logic [SB-1:0]     best_state;
  logic              clear_ovf;
  logic              busy;
  logic              sym_valid;
  logic [1:0]        sym;
  logic              overflow;
  logic [1:0]        state_dbg;

  int checks;
  int failures;
  int bfill;
  int n_path;
  logic [1:0] exp_q[$];
  logic [1:0] xs [0:2047];

  multih_traceback #(.STATE_BITS(SB), .TB_LEN(TB), .DEPTH(64)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .dec_valid  (dec_valid),
    .dec_vec    (dec_vec),
    .best_state (best_state),
    .clear_ovf  (clear_ovf),
    .busy       (busy),
    .sym_valid  (sym_valid),
    .sym        (sym),
    .overflow   (overflow),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [2*NS-1:0] rand_vec();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [1:0] xsym(input int i);
    return (i < 0) ? 2'b00 : xs[i];
  endfunction

  // Issue one decision vector, then watch WIN cycles.
  //   drop_c: cycle at which a stray dec_valid is driven (0 = none).
  //   clr_c:  cycle at which clear_ovf is pulsed (0 = none).
  //   rst_c:  cycle at which reset is pulsed (0 = none).
  //   exp_ovf: required overflow at the end (-1 = unchecked).
  task automatic issue(input logic [2*NS-1:0] vec, input logic [SB-1:0] best,
                       input logic [1:0] exp_sym, input int drop_c,
                       input int clr_c, input int rst_c, input int exp_ovf);
    logic        trace;
    logic [63:0] bexp, bact, vexp, vact;
    @(negedge clk);
    dec_vec    = vec;
    best_state = best;
    dec_valid  = 1'b1;
    if (bfill < TB) bfill++;
    trace = (bfill == TB);
    if (trace && rst_c == 0) exp_q.push_back(exp_sym);
    bexp = '0; bact = '0; vexp = '0; vact = '0;
    for (int c = 1; c <= WIN; c++) begin
      @(negedge clk);
      dec_valid = 1'b0;
      clear_ovf = 1'b0;
      if (c == drop_c) begin
        dec_valid  = 1'b1;
        dec_vec    = rand_vec();
        best_state = SB'($urandom_range(0, NS - 1));
      end
      if (c == clr_c) clear_ovf = 1'b1;
      if (rst_c != 0 && c == rst_c + 1) reset_n = 1'b1;
      if (c == rst_c) begin
        reset_n = 1'b0;
        #1;
        check("reset_async_outputs", {60'd0, busy, sym_valid, sym, overflow}, 64'd0);
        bfill = 0;
      end
      bact[c] = busy;
      vact[c] = sym_valid;
      bexp[c] = trace && (c <= TB + 1) && (rst_c == 0 || c < rst_c);
      vexp[c] = trace && (rst_c == 0) && (c == TB + 2);
    end
    check("busy_window", bact, bexp);
    check("valid_window", vact, vexp);
    if (exp_ovf >= 0) check("overflow_flag", {63'd0, overflow}, 64'(exp_ovf));
  endtask

  // Next symbol of the known path. The true state carries the newest symbol
  // in its LSBs. The stored decision for that state is the symbol three back.
  task automatic path_vec(input int drop_c, input int clr_c, input int rst_c, input int exp_ovf);
    logic [2*NS-1:0] v;
    logic [SB-1:0]   s;
    int              n;
    n     = n_path;
    xs[n] = 2'($urandom_range(0, 3));
    s     = {xsym(n - 2), xsym(n - 1), xsym(n)};
    v     = rand_vec();
    v[{s, 1'b0} +: 2] = xsym(n - 3);
    n_path++;
    issue(v, s, xsym(n - TB), drop_c, clr_c, rst_c, exp_ovf);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("reset_async_outputs", {60'd0, busy, sym_valid, sym, overflow}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bfill = 0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset_n && sym_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_sym actual=%0h required=none", sym);
      end else begin
        check("sym", {62'd0, sym}, {62'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks     = 0;
    failures   = 0;
    bfill      = 0;
    n_path     = 0;
    reset_n    = 1'b0;
    dec_valid  = 1'b0;
    dec_vec    = '0;
    best_state = '0;
    clear_ovf  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {58'd0, state_dbg, busy, sym_valid, sym, overflow}, 64'd0);
    reset_n = 1'b1;

    // Fill threshold: all-ones decisions from 0x15 converge to state 0x3f.
    for (int i = 0; i < TB; i++) issue({2*NS{1'b1}}, 6'h15, 2'b11, 0, 0, 0, 0);

    // Reset mid-run, then the known path (300 symbols, several pointer wraps).
    do_reset();
    n_path = 0;
    for (int i = 0; i < 300; i++) path_vec(0, 0, 0, -1);

    // Overflow: drop, drop coincident with clear, clear, drop again.
    path_vec(5, 0, 0, 1);
    path_vec(5, 5, 0, 1);
    path_vec(0, 3, 0, 0);
    path_vec(5, 0, 0, 1);
    path_vec(0, 0, 0, 1);

    // Reset mid-trace. The next 31 vectors are silent; then output resumes.
    path_vec(0, 0, 10, -1);
    for (int i = 0; i < TB + 8; i++) path_vec(0, 0, 0, 0);

    repeat (4) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog.
  initial begin
    #5000000;
    failures++;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
